// File: rtl/donut_pkg.sv
// donut_pkg: shared ASCII constants, shade ramp and FSM states for the donut character formatter.
package donut_pkg;
    typedef enum logic [2:0] {S_HOME0, S_HOME1, S_HOME2, S_CHAR, S_CR, S_LF} state_e;
    localparam logic [7:0] ASC_ESC    = 8'h1B;
    localparam logic [7:0] ASC_LBRACK = 8'h5B;
    localparam logic [7:0] ASC_H      = 8'h48;
    localparam logic [7:0] ASC_CR     = 8'h0D;
    localparam logic [7:0] ASC_LF     = 8'h0A;
    localparam logic [7:0] ASC_SPACE  = 8'h20;
    localparam int RAMP_LEN = 12;
    // Index 0 is the darkest shade ('.'), index 11 the brightest ('@').
    localparam logic [RAMP_LEN-1:0][7:0] SHADE_RAMP = {
        8'h40, 8'h24, 8'h23, 8'h2A, 8'h21, 8'h3D,
        8'h3B, 8'h3A, 8'h7E, 8'h2D, 8'h2C, 8'h2E
    };
endpackage

// File: rtl/donut_shade_lut.sv
// donut_shade_lut: maps a luminance index (or blank cell) to its ASCII shade character.
module donut_shade_lut
    import donut_pkg::*;
(
    input  logic [3:0] lum_i,
    input  logic       blank_i,
    output logic [7:0] char_o
);
    logic [3:0] idx;
    assign idx    = (lum_i > 4'd11) ? 4'd11 : lum_i;
    assign char_o = blank_i ? ASC_SPACE : SHADE_RAMP[idx];
endmodule

// File: rtl/donut_char_formatter.sv
// donut_char_formatter: turns a row-major luminance stream into framed ASCII bytes
// (ESC[H header, CR/LF per row) over a single-slot start/txe byte handshake.
module donut_char_formatter
    import donut_pkg::*;
#(
    parameter int COLS = 80,
    parameter int ROWS = 24
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       lum_valid,
    input  logic [3:0] lum,
    input  logic       lum_blank,
    output logic       lum_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_txe,
    output logic       frame_done
);
    localparam int CW = $clog2(COLS) + 1;
    localparam int RW = $clog2(ROWS) + 1;

    state_e        state_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          out_valid_q;
    logic [7:0]    out_byte_q;
    logic          frame_done_q;
    logic [7:0]    shade;
    logic [7:0]    byte_d;
    logic          accept;
    logic          slot_free;
    logic          load;
    logic          last_col;
    logic          last_row;

    donut_shade_lut u_lut (
        .lum_i  (lum),
        .blank_i(lum_blank),
        .char_o (shade)
    );

    assign accept     = out_valid_q && tx_txe;
    assign slot_free  = !out_valid_q || accept;
    assign lum_ready  = (state_q == S_CHAR) && slot_free;
    assign load       = slot_free && ((state_q != S_CHAR) || lum_valid);
    assign last_col   = col_q == CW'(COLS - 1);
    assign last_row   = row_q == RW'(ROWS - 1);
    assign tx_start   = out_valid_q;
    assign tx_data    = out_byte_q;
    assign frame_done = frame_done_q;

    always_comb begin
        byte_d = (state_q == S_HOME0) ? ASC_ESC :
                 (state_q == S_HOME1) ? ASC_LBRACK :
                 (state_q == S_HOME2) ? ASC_H :
                 (state_q == S_CR)    ? ASC_CR :
                 (state_q == S_LF)    ? ASC_LF : shade;
    end

    // In HOME0 the slot can only hold the frame's final LF, so an accept there ends the frame.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= S_HOME0;
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            out_byte_q   <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= accept && (state_q == S_HOME0);
            if (accept)
                out_valid_q <= 1'b0;
            if (load) begin
                out_valid_q <= 1'b1;
                out_byte_q  <= byte_d;
                case (state_q)
                    S_HOME0: state_q <= S_HOME1;
                    S_HOME1: state_q <= S_HOME2;
                    S_HOME2: state_q <= S_CHAR;
                    S_CHAR: begin
                        col_q <= last_col ? '0 : col_q + 1'b1;
                        if (last_col)
                            state_q <= S_CR;
                    end
                    S_CR:    state_q <= S_LF;
                    S_LF: begin
                        row_q   <= last_row ? '0 : row_q + 1'b1;
                        state_q <= last_row ? S_HOME0 : S_CHAR;
                    end
                    default: state_q <= S_HOME0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_donut_char_formatter.sv
// tb_donut_char_formatter: table-driven bench for the donut character formatter (COLS=4, ROWS=2).
module tb_donut_char_formatter;
    localparam int COLS = 4;
    localparam int ROWS = 2;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       lum_valid = 1'b0;
    logic [3:0] lum = 4'd0;
    logic       lum_blank = 1'b0;
    logic       tx_txe = 1'b0;
    logic       lum_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       frame_done;

    donut_char_formatter #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .lum_valid (lum_valid),
        .lum       (lum),
        .lum_blank (lum_blank),
        .lum_ready (lum_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_txe    (tx_txe),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] lum;
        logic       blank;
        logic [7:0] exp;
    } vec_t;

    vec_t       tab[16];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         fd_cnt = 0;
    int         lf_cnt = 0;
    bit         prev_final = 1'b0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Bytes are logged at the negedge before the posedge that accepts them.
    always @(negedge clk) begin
        if (!nrst) begin
            prev_final = 1'b0;
            lf_cnt     = 0;
        end else begin
            chk("frame_done", frame_done, prev_final);
            if (frame_done)
                fd_cnt++;
            prev_final = 1'b0;
            if (tx_start && tx_txe) begin
                got.push_back(tx_data);
                if (tx_data == 8'h0A) begin
                    prev_final = (lf_cnt == ROWS - 1);
                    lf_cnt     = (lf_cnt == ROWS - 1) ? 0 : lf_cnt + 1;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic feed(input int first, input int last, output int stalls);
        int t;
        stalls = 0;
        for (int i = first; i <= last; i++) begin
            t         = 0;
            lum_valid = 1'b1;
            lum       = tab[i].lum;
            lum_blank = tab[i].blank;
            @(negedge clk);
            while (!lum_ready && t < 200) begin
                stalls++;
                t++;
                @(negedge clk);
            end
            if (!lum_ready) begin
                n_cmp++;
                n_bad++;
                $display("FAIL feed_timeout: cell %0d never accepted, expected lum_ready within 200 cycles", i);
                lum_valid = 1'b0;
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        lum_valid = 1'b0;
    endtask

    task automatic push_hdr();
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h5B);
        exp_q.push_back(8'h48);
    endtask

    task automatic push_frame(input int first);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++)
                exp_q.push_back(tab[first + r * COLS + c].exp);
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic compare_stream(input string name);
        int n;
        chk({name, "_len"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_byte%0d", name, i), got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        int st;
        for (int r = 0; r < 2; r++) begin
            tab[r*4+0] = '{4'd0,  1'b0, 8'h2E};
            tab[r*4+1] = '{4'd5,  1'b0, 8'h3B};
            tab[r*4+2] = '{4'd11, 1'b0, 8'h40};
            tab[r*4+3] = '{4'd15, 1'b0, 8'h40};
        end
        tab[8]  = '{4'd7,  1'b1, 8'h20};
        tab[9]  = '{4'd7,  1'b0, 8'h21};
        tab[10] = '{4'd3,  1'b0, 8'h7E};
        tab[11] = '{4'd12, 1'b0, 8'h40};
        tab[12] = '{4'd8,  1'b0, 8'h2A};
        tab[13] = '{4'd9,  1'b0, 8'h23};
        tab[14] = '{4'd10, 1'b0, 8'h24};
        tab[15] = '{4'd1,  1'b0, 8'h2C};

        tx_txe = 1'b1;
        cycles(3);
        @(negedge clk);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_lum_ready", lum_ready, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        @(posedge clk);
        #1;
        nrst = 1'b1;

        cycles(10);
        @(negedge clk);
        chk("idle_tx_start", tx_start, 1'b0);
        chk("idle_lum_ready", lum_ready, 1'b1);
        push_hdr();
        compare_stream("hdr");

        @(posedge clk);
        #1;
        tx_txe = 1'b0;
        feed(0, 0, st);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_tx_start", tx_start, 1'b1);
            chk("bp_tx_data", tx_data, 8'h2E);
            chk("bp_lum_ready", lum_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        tx_txe = 1'b1;
        feed(1, 15, st);
        chk("b2b_stalls", st, 9);
        cycles(20);
        push_frame(0);
        push_hdr();
        push_frame(8);
        push_hdr();
        compare_stream("frames");
        chk("frame_done_count", fd_cnt, 2);

        feed(0, 2, st);
        nrst = 1'b0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(negedge clk);
        chk("mrst_tx_start", tx_start, 1'b0);
        chk("mrst_frame_done", frame_done, 1'b0);
        chk("mrst_tx_data", tx_data, 8'h00);
        chk("mrst_lum_ready", lum_ready, 1'b0);
        @(posedge clk);
        #1;
        feed(0, 3, st);
        cycles(10);
        exp_q.push_back(8'h2E);
        exp_q.push_back(8'h3B);
        push_hdr();
        for (int c = 0; c < COLS; c++)
            exp_q.push_back(tab[c].exp);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        compare_stream("midreset");
        chk("frame_done_count_final", fd_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/donut_char_formatter.md
Name: donut_char_formatter

Overview:
- Sits directly upstream of the UART transmitter.
- Accepts a row-major stream of per-cell luminance values from the donut renderer and maps each one to an ASCII shade character.
- Wraps each frame in terminal framing: an ANSI cursor-home sequence before the frame, and CR/LF after every row.
- Drives the transmitter's start/data_in/txe byte handshake, one byte per accepted transfer.

Parameters:
COLS, 80, characters per row (>=1)
ROWS, 24, rows per frame (>=1)

Ports:
clk  input  1  clock
nrst  input  1  reset, synchronous, active-low
lum_valid  input  1  upstream cell value valid
lum  input  4  cell luminance index, 0 darkest
lum_blank  input  1  cell not covered by the donut; emit space
lum_ready  output  1  cell accepted when lum_valid && lum_ready
tx_start  output  1  byte offer to transmitter (drives its start)
tx_data  output  8  byte to transmit (drives its data_in)
tx_txe  input  1  transmitter buffer-empty flag
frame_done  output  1  one-cycle pulse when the final LF of a frame is accepted

Behaviour:
- Single output slot (out_valid, out_byte). tx_start = out_valid; tx_data = out_byte.
- Byte accepted in any cycle where tx_start && tx_txe. The transmitter may report txe high on consecutive cycles; each such cycle consumes one byte.
- Slot is free for reload when !out_valid || (tx_start && tx_txe), i.e. one byte per cycle maximum.
- tx_data is held stable while tx_start=1 and tx_txe=0.
- Reset (nrst=0 at posedge, including mid-frame): out_valid=0, tx_start=0, tx_data=8'h00, lum_ready=0, frame_done=0, state=HOME0, col=0, row=0. A partially sent frame is abandoned. The next frame restarts with ESC.
- FSM states and the byte each loads when the slot is free:
  - HOME0: load 8'h1B (ESC) -> HOME1
  - HOME1: load 8'h5B ('[') -> HOME2
  - HOME2: load 8'h48 ('H') -> CHAR
  - CHAR: lum_ready = slot free. On lum_valid && lum_ready, load shade(lum, lum_blank).
    - col==COLS-1: col<=0, next state CR.
    - Otherwise: col<=col+1, stay in CHAR.
  - CR: load 8'h0D -> LF
  - LF: load 8'h0A.
    - row==ROWS-1: row<=0, next state HOME0.
    - Otherwise: row<=row+1, next state CHAR.
- lum_ready is 0 in every state other than CHAR. Upstream stalls during framing bytes.
- Shade mapping:
  - lum_blank=1 -> 8'h20 (space).
  - Otherwise lum 0..11 index the ramp ".,-~:;=!*#$@" (8'h2E,2C,2D,7E,3A,3B,3D,21,2A,23,24,40).
  - lum 12..15 clamp to '@' (8'h40).
- Latency: a cell accepted in cycle N appears on tx_data with tx_start=1 from cycle N+1.
- frame_done: asserted the cycle after the last-row LF is accepted by the transmitter (not when it is loaded).
- Width rules:
  - col is $clog2(COLS)+1 bits; row is $clog2(ROWS)+1 bits. Both wrap only via the terminal compare, never by overflow.
  - COLS=1 and ROWS=1 are legal: every row is one char + CR + LF.
- Simultaneous accept and reload in the same cycle is legal. out_valid stays 1 and out_byte takes the new value.

Decomposition:
- Shared package donut_pkg:
  - shade ramp constant array (12 x 8-bit)
  - ASCII constants ESC, LBRACK, H, CR, LF, SPACE
  - FSM state enum (HOME0, HOME1, HOME2, CHAR, CR, LF)
- One natural sub-module: donut_shade_lut, purely combinational, mapping (lum, lum_blank) -> 8-bit ASCII. The FSM, counters and output slot stay in donut_char_formatter.

Test Plan:
- Reset then idle with tx_txe=1, COLS=4, ROWS=2, lum_valid=0:
  - tx_data sequence 1B,5B,48.
  - Then tx_start=0 and lum_ready=1; no further bytes.
- Feed lum 0,5,11,15 with tx_txe=1 always (COLS=4, ROWS=2):
  - Bytes 2E,3B,40,40,0D,0A.
  - Then row 2 of the same values, then 2E,3B,40,40,0D,0A again.
  - frame_done pulses once, one cycle after the second 0A is accepted.
  - Next bytes are 1B,5B,48.
- Backpressure:
  - Hold tx_txe=0 for 10 cycles with a byte pending: tx_data stays constant, tx_start=1, lum_ready=0.
  - Release: exactly one byte is accepted per tx_txe-high cycle; no byte is lost or duplicated.
- lum_blank=1 with lum=7: emits 20, not 21. lum_blank=0 with lum=7: emits 21.
- Reset mid-frame, after 3 cells of row 1: nrst low for 1 cycle.
  - tx_start=0, frame_done=0 the cycle after reset.
  - Next emitted bytes are 1B,5B,48 then the new cells; col/row restart at 0.
- Back-to-back: lum_valid=1 continuously with tx_txe=1:
  - Throughput is 1 byte/cycle in CHAR.
  - lum_ready drops for exactly the CR, LF and header bytes.
